// File: rtl/inteiro_para_flutuante.sv
// Signed 32-bit integer to {sign, exp[5:0], man[24:0]} float; one normalising shift per cycle, done k+3 edges after start.
// Backpressure: start is only sampled in IDLE, and requests made while busy are dropped rather than queued.
module inteiro_para_flutuante #(
  parameter int unsigned BIAS = 31
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic [2:0]  qual_lugar
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    NORMALIZE = 3'd2,
    PACK      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   operand_q, operand_d;
  logic [31:0]   mag_q, mag_d;
  logic          sign_q, sign_d;
  logic [4:0]    k_q, k_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    status_q, status_d;
  logic signed [8:0] exp_w;

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      operand_q <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      k_q       <= '0;
      data_q    <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      k_q       <= k_d;
      data_q    <= data_d;
      status_q  <= status_d;
    end
  end

  // Unbiased exponent is 31-k; held in 9 bits so both overflow and underflow stay visible.
  always_comb begin
    exp_w = 9'(BIAS + 31) - 9'(k_q);
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    k_d       = k_q;
    data_d    = data_q;
    status_d  = status_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = int_in;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        sign_d  = operand_q[31];
        mag_d   = operand_q[31] ? (~operand_q + 32'd1) : operand_q;
        k_d     = 5'd0;
        state_d = (operand_q == 32'd0) ? PACK : NORMALIZE;
      end
      NORMALIZE: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          k_d   = k_q + 5'd1;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        if (mag_q == 32'd0) begin
          data_d   = 32'd0;
          status_d = 4'd0;
        end else if (exp_w >= 9'sd63) begin
          data_d   = {sign_q, 6'h3F, 25'd0};
          status_d = 4'd1;
        end else if (exp_w <= 9'sd0) begin
          data_d   = {sign_q, 31'd0};
          status_d = 4'd2;
        end else begin
          data_d   = {sign_q, exp_w[5:0], mag_q[30:6]};
          status_d = (mag_q[5:0] != 6'd0) ? 4'd3 : 4'd0;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign data_out   = data_q;
  assign status_out = status_q;
  assign qual_lugar = state_q;

endmodule

// File: tb/tb_inteiro_para_flutuante.sv
// Scoreboard bench: three encoders (BIAS 31, 0, 40) share one stimulus stream; a monitor checks every done pulse.
module tb_inteiro_para_flutuante;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] int_in = 32'd0;

  logic        busy_31, done_31, busy_00, done_00, busy_40, done_40;
  logic [31:0] data_31, data_00, data_40;
  logic [3:0]  stat_31, stat_00, stat_40;
  logic [2:0]  qual_31, qual_00, qual_40;

  inteiro_para_flutuante #(.BIAS(31)) dut_31 (
    .clock_100kHz(clk), .reset(rst_n), .start(start), .int_in(int_in),
    .busy(busy_31), .done(done_31), .data_out(data_31), .status_out(stat_31), .qual_lugar(qual_31));
  inteiro_para_flutuante #(.BIAS(0)) dut_00 (
    .clock_100kHz(clk), .reset(rst_n), .start(start), .int_in(int_in),
    .busy(busy_00), .done(done_00), .data_out(data_00), .status_out(stat_00), .qual_lugar(qual_00));
  inteiro_para_flutuante #(.BIAS(40)) dut_40 (
    .clock_100kHz(clk), .reset(rst_n), .start(start), .int_in(int_in),
    .busy(busy_40), .done(done_40), .data_out(data_40), .status_out(stat_40), .qual_lugar(qual_40));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] d31, d00, d40;
    logic [3:0]  s31, s00, s40;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_31 = 32'd0, last_00 = 32'd0, last_40 = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: locate the leading one arithmetically, take the 25 bits below it, flag any dropped ones.
  function automatic void ref_model(input logic [31:0] x, input int bias,
                                    output logic [31:0] d, output logic [3:0] s, output int lat);
    longint m, frac, man;
    int     p, e;
    bit     sg, inex;
    sg = x[31];
    m  = sg ? -longint'($signed(x)) : longint'(x);
    if (m == 0) begin
      d = 32'd0; s = 4'd0; lat = 2;
      return;
    end
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e    = bias + p;
    lat  = 34 - p;
    frac = m - (longint'(1) << p);
    if (p >= 25) begin
      man  = frac >> (p - 25);
      inex = (frac % (longint'(1) << (p - 25))) != 0;
    end else begin
      man  = frac << (25 - p);
      inex = 1'b0;
    end
    if (e >= 63) begin
      d = {sg, 6'h3F, 25'd0}; s = 4'd1;
    end else if (e <= 0) begin
      d = {sg, 31'd0}; s = 4'd2;
    end else begin
      d = {sg, 6'(e), 25'(man)}; s = inex ? 4'd3 : 4'd0;
    end
  endfunction

  function automatic exp_t make_exp(input logic [31:0] v, input int t0);
    exp_t r;
    int   lat;
    ref_model(v, 31, r.d31, r.s31, lat);
    ref_model(v, 0,  r.d00, r.s00, lat);
    ref_model(v, 40, r.d40, r.s40, lat);
    r.t = t0 + lat;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_31 && n < 200) begin step(); n++; end
    if (busy_31) chk("idle_timeout", 32'(busy_31), 32'd0);
  endtask

  task automatic check_held();
    chk("hold_data_b31", data_31, last_31);
    chk("hold_data_b0",  data_00, last_00);
    chk("hold_data_b40", data_40, last_40);
  endtask

  task automatic check_reset_state();
    chk("rst_outs_b31", {busy_31, done_31, qual_31, stat_31, data_31}, 41'd0);
    chk("rst_outs_b0",  {busy_00, done_00, qual_00, stat_00, data_00}, 41'd0);
    chk("rst_outs_b40", {busy_40, done_40, qual_40, stat_40, data_40}, 41'd0);
    chk("rst_data_b31", data_31, 32'd0);
  endtask

  task automatic issue(input logic [31:0] v);
    exp_t e;
    wait_idle();
    check_held();
    start  = 1'b1;
    int_in = v;
    e = make_exp(v, cyc + 1);
    exp_q.push_back(e);
    last_31 = e.d31; last_00 = e.d00; last_40 = e.d40;
    step();
    start  = 1'b0;
    int_in = $urandom;
  endtask

  task automatic back_to_back(input logic [31:0] v1, input logic [31:0] v2);
    exp_t e1, e2;
    int   c, lat1, n;
    logic [31:0] dd;
    logic [3:0]  ss;
    wait_idle();
    check_held();
    c = cyc;
    ref_model(v1, 31, dd, ss, lat1);
    start  = 1'b1;
    int_in = v1;
    e1 = make_exp(v1, c + 1);
    e2 = make_exp(v2, c + 1 + lat1 + 2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    last_31 = e2.d31; last_00 = e2.d00; last_40 = e2.d40;
    step();
    int_in = v2;
    n = 0;
    while (cyc < c + lat1 + 3 && n < 100) begin step(); n++; end
    start  = 1'b0;
    int_in = $urandom;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done_31 || done_00 || done_40)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {29'd0, done_31, done_00, done_40}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("latency",   32'(cyc), 32'(e.t));
        chk("done_all",  {29'd0, done_31, done_00, done_40}, 32'd7);
        chk("data_b31",  data_31, e.d31);
        chk("stat_b31",  32'(stat_31), 32'(e.s31));
        chk("data_b0",   data_00, e.d00);
        chk("stat_b0",   32'(stat_00), 32'(e.s00));
        chk("data_b40",  data_40, e.d40);
        chk("stat_b40",  32'(stat_40), 32'(e.s40));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int n;
    rst_n = 1'b0;
    #23;
    check_reset_state();
    step();
    rst_n = 1'b1;
    step();

    issue(32'd1);
    issue(32'hFFFF_FFFF);
    issue(32'd3);
    issue(32'h8000_0000);
    issue(32'd0);
    issue(32'h7FFF_FFFF);

    // A start pulse while converting must be dropped without a second done.
    issue(32'd1);
    step(); step(); step();
    start = 1'b1; int_in = 32'd5;
    step();
    start = 1'b0;

    back_to_back(32'd12345, 32'hFFFF_0001);

    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 9) == 0) v = 32'd0;
      issue(v);
    end

    // Abort in the middle of normalisation: everything clears and no done appears.
    issue(32'd1);
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    exp_q.delete();
    last_31 = 32'd0; last_00 = 32'd0; last_40 = 32'd0;
    #1;
    check_reset_state();
    step(); step();
    rst_n = 1'b1;
    step();
    issue(32'd3);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin step(); n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check_held();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
